flits_buffer: RTL and testbench
===============================

# flits_buffer

Receive-side flit buffer of the NIC: collects the flits of one incoming NoC packet into a circular array of `MAX_PACKET_LENGHT` slots and exposes the whole array flattened. When the packet is complete it requests packet-to-message conversion, then returns one credit per flit slot to the upstream router. It sits between the router ejection link and the packet-to-message converter.

## Interface
- `N_BITS_POINTER`, default `clog2(MAX_PACKET_LENGHT)`: slot index width.
- Global macros: `FLIT_WIDTH` = 64 and `MAX_PACKET_LENGHT` = 8, both power-of-two sizes.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_link_i` input `FLIT_WIDTH`: incoming flit. Bits [1:0] are the type: 00 head, 01 body, 10 tail, 11 head-tail.
- `is_valid_i` input 1: `in_link_i` is valid this cycle.
- `credit_signal_o` output 1: one-cycle pulse per freed slot.
- `free_signal_o` output 1: buffer idle and empty.
- `g_pkt_to_msg_i` input 1: grant from the converter.
- `r_pkt_to_msg_o` output 1: complete packet available (request).
- `out_link_o` output `MAX_PACKET_LENGHT*FLIT_WIDTH`: all slots flattened; slot k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH].
- `head_pointer_o` output `N_BITS_POINTER`: slot holding the head flit of the current packet.
- `out_sel_o` output `MAX_PACKET_LENGHT`: bitmask of the slots occupied by the current packet.

## Operation
- The FSM has four states: IDLE, RECEIVING, REQUEST, RELEASE.
- **Write pointer `wp`**
  - Wraps modulo `MAX_PACKET_LENGHT`.
  - It is not reset between packets: a new packet starts where the previous one ended.
- **IDLE**
  - `free_signal_o` = 1.
  - Valid head: write to slot `wp`, set `head_pointer_o` = `wp`, set `out_sel_o` = one-hot(`wp`), increment `wp`, go to RECEIVING.
  - Valid head-tail: same writes, then go directly to REQUEST.
  - Body or tail: dropped.
- **RECEIVING**
  - Valid body or tail: write to slot `wp`, set bit `wp` in `out_sel_o`, increment `wp`, increment the flit count.
  - Tail: go to REQUEST.
  - New head: restarts the packet at the current `wp`.
  - Once the count reaches `MAX_PACKET_LENGHT`, further body flits are dropped; a tail still completes the packet, but is not stored.
- **REQUEST**
  - `r_pkt_to_msg_o` = 1.
  - Any valid flit is dropped (upstream never sends without credit).
  - On `g_pkt_to_msg_i` = 1: clear `out_sel_o`, load the credit counter with the flit count, go to RELEASE.
- **RELEASE**
  - `credit_signal_o` = 1 for count consecutive cycles.
  - Then go to IDLE.
  - Valid flits arriving in RELEASE are dropped.
- `g_pkt_to_msg_i` is ignored outside REQUEST.
- Slot data is never cleared; only `out_sel_o` defines which slots are valid.

## Timing
- **Reset values:**
  - FSM = IDLE, `wp` = 0.
  - `head_pointer_o` = 0, `out_sel_o` = 0.
  - `r_pkt_to_msg_o` = 0, `credit_signal_o` = 0, `free_signal_o` = 1.
  - Slots = 0.
- **Write latency:** a flit sampled at posedge N is visible on `out_link_o` after edge N.
- **Request latency:** `r_pkt_to_msg_o` rises after the edge that stores the tail or head-tail.
- **Grant:** sampled at the edge where `r_pkt_to_msg_o` = 1. After that edge, `r_pkt_to_msg_o` = 0 and the first credit pulse is high.
- `free_signal_o` returns to 1 the cycle after the last credit pulse.
- **Wrap-around:** slot `MAX_PACKET_LENGHT-1` is followed by slot 0. `out_sel_o` may be non-contiguous across the wrap.
- **Reset mid-packet:** everything returns to the reset values immediately; no credits are issued for the lost flits.
- All outputs are registered.

## Configuration
- `FLITS_BUFFER_CHECK_EN` defined: simulation-only checks report `$error` when any of these occur:
  - a flit is dropped;
  - body or tail arrives in IDLE;
  - a head arrives in RECEIVING;
  - the packet overflows.
- Undefined: no checks.
- Synthesized logic is identical either way.

## Structure
- **Shared NIC package/defines:**
  - `FLIT_WIDTH`, `MAX_PACKET_LENGHT`;
  - flit type constants (HEAD=2'b00, BODY=2'b01, TAIL=2'b10, HEADTAIL=2'b11);
  - the `clog2` function.
- **Sub-module `flits_buffer_credit_gen`:** loadable down-counter producing the `credit_signal_o` pulse train and a done flag.

## Test plan
- **Reset:** after reset, `free_signal_o`=1, `r_pkt_to_msg_o`=0, `out_sel_o`=0, `head_pointer_o`=0.
- **Single-flit packet:** head-tail 64'hFF3 with valid for 1 cycle.
  - Slot 0 = 0xFF3, `head_pointer_o`=0, `out_sel_o`=8'h01, `r_pkt_to_msg_o`=1 from the next cycle.
  - Hold `r_pkt_to_msg_o` 3 cycles, then a 1-cycle grant: exactly one credit pulse, `free_signal_o`=1 afterwards.
- **Five-flit packet with a bubble, starting at `wp`=1:** 0x00, 0x11, 0x21, one idle cycle, 0x31, 0x72.
  - Slots 1..5 = 00, 11, 21, 31, 72; `head_pointer_o`=1, `out_sel_o`=8'h3E.
  - Grant: five consecutive credit pulses.
- **Wrap:** a packet of 4 flits starting at `wp`=6 fills slots 6, 7, 0, 1; `out_sel_o`=8'hC3, `head_pointer_o`=6.
- **Drops:** each of these leaves the state unchanged and produces no credit:
  - tail 0x72 while IDLE;
  - a flit during REQUEST;
  - grant while IDLE.
- **Reset during RECEIVING:** 2 flits stored, then `rst` pulse: all outputs return to the reset values and no credits are issued.

Source files
------------

// File: rtl/flits_buffer_pkg.sv
// flits_buffer_pkg: shared NIC sizes, flit type codes, buffer FSM states and clog2 helper
package flits_buffer_pkg;
   localparam int FLIT_WIDTH = 64;
   localparam int MAX_PACKET_LENGHT = 8;
   localparam logic [1:0] HEAD = 2'b00;
   localparam logic [1:0] BODY = 2'b01;
   localparam logic [1:0] TAIL = 2'b10;
   localparam logic [1:0] HEADTAIL = 2'b11;
   typedef enum logic [1:0] {IDLE, RECEIVING, REQUEST, RELEASE} state_t;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/flits_buffer_credit_gen.sv
// flits_buffer_credit_gen: loadable down-counter emitting one credit pulse per freed slot
//   clk, rst   : clock, asynchronous active-high reset
//   load       : start a pulse train of length count (count >= 1)
//   count      : number of credits to return
//   credit     : registered pulse, high for count consecutive cycles after load
//   done       : high during the last pulse of the train
module flits_buffer_credit_gen #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] count,
   output logic         credit,
   output logic         done
);
   logic [W-1:0] left;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         left <= '0;
         credit <= 1'b0;
      end else if (load) begin
         left <= count - 1'b1;
         credit <= 1'b1;
      end else begin
         left <= left != '0 ? left - 1'b1 : left;
         credit <= left != '0;
      end
   assign done = credit && left == '0;
endmodule

// File: rtl/flits_buffer.sv
// flits_buffer: NIC receive-side circular flit buffer with packet request and credit return
//   clk, rst        : clock, asynchronous active-high reset
//   in_link_i       : incoming flit, bits [1:0] = type (00 head, 01 body, 10 tail, 11 head-tail)
//   is_valid_i      : in_link_i valid this cycle
//   credit_signal_o : one pulse per freed slot after the grant
//   free_signal_o   : buffer idle and empty
//   g_pkt_to_msg_i  : grant from the packet-to-message converter
//   r_pkt_to_msg_o  : complete packet available
//   out_link_o      : all slots flattened, slot k at [k*FLIT_WIDTH +: FLIT_WIDTH]
//   head_pointer_o  : slot holding the head flit of the current packet
//   out_sel_o       : bitmask of slots occupied by the current packet
// Define FLITS_BUFFER_CHECK_EN to enable simulation-only $error reports on dropped flits,
// protocol violations and overflow; synthesized logic is the same either way.
module flits_buffer
   import flits_buffer_pkg::*;
#(
   parameter int N_BITS_POINTER = clog2(MAX_PACKET_LENGHT)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [FLIT_WIDTH-1:0]                 in_link_i,
   input  logic                                  is_valid_i,
   output logic                                  credit_signal_o,
   output logic                                  free_signal_o,
   input  logic                                  g_pkt_to_msg_i,
   output logic                                  r_pkt_to_msg_o,
   output logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] out_link_o,
   output logic [N_BITS_POINTER-1:0]             head_pointer_o,
   output logic [MAX_PACKET_LENGHT-1:0]          out_sel_o
);
   localparam logic [N_BITS_POINTER:0] FULL = (N_BITS_POINTER+1)'(MAX_PACKET_LENGHT);
   state_t state, state_n;
   logic [N_BITS_POINTER-1:0] wp, wp_n, head_n;
   logic [N_BITS_POINTER:0] cnt, cnt_n;
   logic [MAX_PACKET_LENGHT-1:0] sel_n, onehot;
   logic [FLIT_WIDTH-1:0] slots [MAX_PACKET_LENGHT];
   logic [1:0] ft;
   logic is_head, we, load, done;
   assign ft = in_link_i[1:0];
   assign is_head = ft == HEAD || ft == HEADTAIL;
   assign onehot = {{(MAX_PACKET_LENGHT-1){1'b0}}, 1'b1} << wp;
   always_comb begin
      state_n = state;
      wp_n = wp;
      head_n = head_pointer_o;
      sel_n = out_sel_o;
      cnt_n = cnt;
      we = 1'b0;
      load = 1'b0;
      case (state)
         IDLE, RECEIVING:
            if (is_valid_i && is_head) begin
               // a head always (re)starts the packet at the current write pointer
               we = 1'b1;
               head_n = wp;
               sel_n = onehot;
               wp_n = wp + 1'b1;
               cnt_n = (N_BITS_POINTER+1)'(1);
               state_n = ft == HEAD ? RECEIVING : REQUEST;
            end else if (is_valid_i && state == RECEIVING) begin
               // past a full buffer the tail only closes the packet, it is not stored
               if (cnt != FULL) begin
                  we = 1'b1;
                  sel_n = out_sel_o | onehot;
                  wp_n = wp + 1'b1;
                  cnt_n = cnt + 1'b1;
               end
               state_n = ft == TAIL ? REQUEST : RECEIVING;
            end
         REQUEST:
            if (g_pkt_to_msg_i) begin
               sel_n = '0;
               load = 1'b1;
               state_n = RELEASE;
            end
         default:
            state_n = done ? IDLE : RELEASE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         wp <= '0;
         cnt <= '0;
         head_pointer_o <= '0;
         out_sel_o <= '0;
         r_pkt_to_msg_o <= 1'b0;
         free_signal_o <= 1'b1;
         for (int k = 0; k < MAX_PACKET_LENGHT; k++) slots[k] <= '0;
      end else begin
         state <= state_n;
         wp <= wp_n;
         cnt <= cnt_n;
         head_pointer_o <= head_n;
         out_sel_o <= sel_n;
         r_pkt_to_msg_o <= state_n == REQUEST;
         free_signal_o <= state_n == IDLE;
         if (we) slots[wp] <= in_link_i;
      end
   for (genvar g = 0; g < MAX_PACKET_LENGHT; g++) begin : g_out
      assign out_link_o[g*FLIT_WIDTH +: FLIT_WIDTH] = slots[g];
   end
   flits_buffer_credit_gen #(.W(N_BITS_POINTER+1)) u_credit (
      .clk(clk),
      .rst(rst),
      .load(load),
      .count(cnt),
      .credit(credit_signal_o),
      .done(done)
   );
`ifdef FLITS_BUFFER_CHECK_EN
   always @(posedge clk)
      if (!rst && is_valid_i) begin
         if (state == IDLE && !is_head) $error("flits_buffer: body/tail dropped in IDLE");
         if (state == RECEIVING && is_head) $error("flits_buffer: head in RECEIVING restarts packet");
         if (state == RECEIVING && !is_head && cnt == FULL) $error("flits_buffer: packet overflow, flit dropped");
         if (state == REQUEST || state == RELEASE) $error("flits_buffer: flit dropped in %s", state.name());
      end
`endif
endmodule

// File: tb/tb_flits_buffer.sv
// tb_flits_buffer: randomized scoreboard bench for flits_buffer
module tb_flits_buffer;
   import flits_buffer_pkg::*;
   localparam int M = MAX_PACKET_LENGHT;
   localparam int W = FLIT_WIDTH;
   localparam int LW = M * W;
   localparam int P = clog2(M);
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [W-1:0] in_link = '0;
   logic is_valid = 1'b0;
   logic grant = 1'b0;
   logic credit, free, req;
   logic [LW-1:0] out_link;
   logic [P-1:0] head;
   logic [M-1:0] sel;
   int total = 0;
   int bad = 0;
   flits_buffer dut (
      .clk(clk),
      .rst(rst),
      .in_link_i(in_link),
      .is_valid_i(is_valid),
      .credit_signal_o(credit),
      .free_signal_o(free),
      .g_pkt_to_msg_i(grant),
      .r_pkt_to_msg_o(req),
      .out_link_o(out_link),
      .head_pointer_o(head),
      .out_sel_o(sel)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [P-1:0] head;
      logic [M-1:0] sel;
      logic [LW-1:0] link;
      int n;
   } exp_t;
   exp_t exp_q[$];
   logic [W-1:0] m_mem [M];
   int m_wp;
   logic [P-1:0] m_head;
   logic [W-1:0] pkt[$];
   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [LW-1:0] model_link();
      logic [LW-1:0] l;
      for (int k = 0; k < M; k++) l[k*W +: W] = m_mem[k];
      return l;
   endfunction
   task automatic model_reset();
      for (int k = 0; k < M; k++) m_mem[k] = '0;
      m_wp = 0;
      m_head = '0;
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic build_pkt(input int n);
      logic [W-1:0] d;
      pkt.delete();
      for (int i = 0; i < n; i++) begin
         d = {$urandom, $urandom};
         d[1:0] = n == 1 ? HEADTAIL : i == 0 ? HEAD : i == n - 1 ? TAIL : BODY;
         pkt.push_back(d);
      end
   endtask
   task automatic send_pkt(input int bubble_at, input bit rnd_bub, input int hold, input bit req_flit);
      int n;
      int ns;
      exp_t e;
      n = pkt.size();
      ns = n < M ? n : M;
      e.head = P'(m_wp);
      e.sel = '0;
      for (int k = 0; k < ns; k++) begin
         m_mem[(m_wp + k) % M] = pkt[k];
         e.sel[(m_wp + k) % M] = 1'b1;
      end
      m_head = P'(m_wp);
      m_wp = (m_wp + ns) % M;
      e.link = model_link();
      e.n = ns;
      exp_q.push_back(e);
      for (int i = 0; i < n; i++) begin
         if (i == bubble_at || (rnd_bub && $urandom_range(0, 3) == 0)) begin
            is_valid = 1'b0;
            in_link = {$urandom, $urandom};
            cyc();
         end
         is_valid = 1'b1;
         in_link = pkt[i];
         cyc();
         if (i == 0) chk("busy", LW'(free), LW'(0));
      end
      is_valid = 1'b0;
      chk("req_latency", LW'(req), LW'(1));
      for (int k = 0; k < hold; k++) begin
         if (req_flit && k == 0) begin
            is_valid = 1'b1;
            in_link = {$urandom, $urandom};
         end
         cyc();
         is_valid = 1'b0;
         chk("req_hold", LW'(req), LW'(1));
      end
      grant = 1'b1;
      cyc();
      grant = 1'b0;
      chk("req_after_grant", LW'(req), LW'(0));
      chk("credit_first", LW'(credit), LW'(1));
      chk("sel_cleared", LW'(sel), LW'(0));
      chk("link_kept", out_link, model_link());
      for (int k = 1; k < ns; k++) begin
         cyc();
         chk("credit_train", LW'(credit), LW'(1));
         chk("free_in_release", LW'(free), LW'(0));
      end
      cyc();
      chk("credit_end", LW'(credit), LW'(0));
      chk("free_after", LW'(free), LW'(1));
   endtask
   task automatic idle_drop(input logic [W-1:0] f);
      is_valid = 1'b1;
      in_link = f;
      cyc();
      is_valid = 1'b0;
      chk("drop_free", LW'(free), LW'(1));
      chk("drop_req", LW'(req), LW'(0));
      chk("drop_sel", LW'(sel), LW'(0));
      chk("drop_head", LW'(head), LW'(m_head));
      chk("drop_link", out_link, model_link());
   endtask
   // monitor: checks each presented packet against the scoreboard and counts credit bursts
   initial begin
      exp_t e;
      logic r_prev;
      int burst;
      int cur_n;
      r_prev = 1'b0;
      burst = 0;
      cur_n = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            r_prev = 1'b0;
            burst = 0;
            cur_n = 0;
         end else begin
            if (req && !r_prev) begin
               chk("req_pending", LW'(exp_q.size() != 0), LW'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("pkt_head", LW'(head), LW'(e.head));
                  chk("pkt_sel", LW'(sel), LW'(e.sel));
                  chk("pkt_link", out_link, e.link);
                  cur_n = e.n;
               end
            end
            if (credit) burst++;
            else if (burst > 0) begin
               chk("credit_count", LW'(burst), LW'(cur_n));
               burst = 0;
               cur_n = 0;
            end
            if (cur_n == 0) chk("stray_credit", LW'(credit), LW'(0));
            r_prev = req;
         end
      end
   end
   initial begin
      model_reset();
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk("rst_free", LW'(free), LW'(1));
      chk("rst_req", LW'(req), LW'(0));
      chk("rst_sel", LW'(sel), LW'(0));
      chk("rst_head", LW'(head), LW'(0));
      chk("rst_credit", LW'(credit), LW'(0));
      chk("rst_link", out_link, LW'(0));
      pkt.delete();
      pkt.push_back(64'hFF3);
      send_pkt(-1, 1'b0, 3, 1'b0);
      idle_drop(64'h72);
      grant = 1'b1;
      cyc();
      grant = 1'b0;
      chk("idle_grant_req", LW'(req), LW'(0));
      chk("idle_grant_credit", LW'(credit), LW'(0));
      cyc();
      chk("idle_grant_free", LW'(free), LW'(1));
      pkt.delete();
      pkt.push_back(64'h00);
      pkt.push_back(64'h11);
      pkt.push_back(64'h21);
      pkt.push_back(64'h31);
      pkt.push_back(64'h72);
      send_pkt(3, 1'b0, 1, 1'b0);
      build_pkt(4);
      send_pkt(-1, 1'b0, 2, 1'b1);
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 2) == 0) begin
            logic [W-1:0] d;
            d = {$urandom, $urandom};
            d[1:0] = $urandom_range(0, 1) == 0 ? BODY : TAIL;
            idle_drop(d);
         end
         build_pkt($urandom_range(1, 10));
         send_pkt(-1, 1'b1, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      end
      build_pkt(4);
      is_valid = 1'b1;
      in_link = pkt[0];
      cyc();
      in_link = pkt[1];
      cyc();
      is_valid = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      chk("mid_rst_free", LW'(free), LW'(1));
      chk("mid_rst_req", LW'(req), LW'(0));
      chk("mid_rst_sel", LW'(sel), LW'(0));
      chk("mid_rst_head", LW'(head), LW'(0));
      chk("mid_rst_credit", LW'(credit), LW'(0));
      chk("mid_rst_link", out_link, model_link());
      cyc();
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("post_rst_credit", LW'(credit), LW'(0));
      end
      build_pkt(3);
      send_pkt(-1, 1'b1, 1, 1'b0);
      cyc();
      cyc();
      chk("queue_empty", LW'(exp_q.size()), LW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
